// File: rtl/seq_div_signed.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit
// per clock, then a sign fix. Truncating semantics (quotient toward zero).
module seq_div_signed #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          overflow
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] qmag_q;
    logic [VW:0]   dmag_q;
    logic [VW:0]   rem_q;
    logic [CW-1:0] cnt_q;
    logic          qneg_q;
    logic          rneg_q;
    logic          zero_q;

    logic [DW-1:0] dividend_abs;
    logic [VW:0]   divisor_ext;
    logic [VW:0]   divisor_abs;
    logic [VW:0]   sr;
    logic [VW:0]   diff;
    logic          ge;
    logic [DW-1:0] q_fix;
    logic [VW:0]   r_fix;

    // -2^(DW-1) maps to 2^(DW-1), which still fits unsigned in DW bits.
    assign dividend_abs = dividend[DW-1] ? -dividend : dividend;
    assign divisor_ext  = {divisor[VW-1], divisor};
    assign divisor_abs  = divisor[VW-1] ? -divisor_ext : divisor_ext;

    // Partial remainder stays below |divisor| <= 2^(VW-1), so the shift never loses a bit.
    assign sr   = {rem_q[VW-1:0], qmag_q[DW-1]};
    assign ge   = (sr >= dmag_q);
    assign diff = sr - dmag_q;

    assign q_fix = qneg_q ? -qmag_q : qmag_q;
    assign r_fix = rneg_q ? -rem_q : rem_q;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = (divisor == '0) ? FIX : CALC;
            CALC: if (cnt_q == CW'(1)) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            qmag_q      <= '0;
            dmag_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            zero_q      <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        zero_q <= (divisor == '0);
                        qmag_q <= dividend_abs;
                        dmag_q <= divisor_abs;
                        qneg_q <= dividend[DW-1] ^ divisor[VW-1];
                        rneg_q <= dividend[DW-1];
                        rem_q  <= '0;
                        cnt_q  <= CW'(DW);
                    end
                end
                CALC: begin
                    rem_q  <= ge ? diff : sr;
                    qmag_q <= {qmag_q[DW-2:0], ge};
                    cnt_q  <= cnt_q - CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (zero_q) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= q_fix;
                        remainder   <= VW'(r_fix);
                        div_by_zero <= 1'b0;
                        // A positive magnitude of 2^(DW-1) is the only unrepresentable quotient.
                        overflow    <= ~qneg_q & qmag_q[DW-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_signed.sv
// Bench for seq_div_signed: directed scenarios plus a full sweep, all results
// checked against an integer / and % reference through an expected queue.
module tb_seq_div_signed;

    localparam int DW = 8;
    localparam int VW = 4;
    localparam int EW = DW + VW + 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];

    seq_div_signed #(.DW(DW), .VW(VW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: {quotient, remainder, div_by_zero, overflow}
    function automatic logic [EW-1:0] model(input int a, input int v);
        int q;
        int r;
        logic [DW-1:0] qb;
        logic [VW-1:0] rb;
        if (v == 0) return {{DW{1'b0}}, {VW{1'b0}}, 1'b1, 1'b0};
        if (a == -128 && v == -1) return {8'h80, {VW{1'b0}}, 1'b0, 1'b1};
        q = a / v;
        r = a % v;
        qb = q[DW-1:0];
        rb = r[VW-1:0];
        return {qb, rb, 2'b00};
    endfunction

    // Called at a negedge: drives one start pulse, waits for done, pops and compares.
    task automatic run_op(input int a, input int v, input string tag);
        logic [EW-1:0] exp;
        logic [EW-1:0] got;
        int lat;
        int busy_cnt;
        int exp_lat;
        exp_q.push_back(model(a, v));
        exp_lat = (v == 0) ? 1 : DW + 1;
        dividend = a[DW-1:0];
        divisor  = v[VW-1:0];
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = DW'($urandom_range(0, 255));
        divisor  = VW'($urandom_range(0, 15));
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: no done after %0d cycles, required %0d", tag, lat, exp_lat);
            void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        got = {quotient, remainder, div_by_zero, overflow};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s result %0d/%0d: got q=%h r=%h dz=%b ov=%b, required q=%h r=%h dz=%b ov=%b",
                     tag, a, v, got[EW-1:VW+2], got[VW+1:2], got[1], got[0],
                     exp[EW-1:VW+2], exp[VW+1:2], exp[1], exp[0]);
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s latency %0d/%0d: got %0d, required %0d", tag, a, v, lat, exp_lat);
        end
        total++;
        if (busy_cnt !== exp_lat || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy %0d/%0d: busy cycles %0d (busy at done=%b), required %0d (0)",
                     tag, a, v, busy_cnt, busy, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            bad++;
            $display("FAIL reset outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(7, 3, "d_7_3");
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
        total++;
        if (quotient !== 8'd2 || remainder !== 4'd1) begin
            bad++;
            $display("FAIL hold: got q=%h r=%h after done, required 02 1", quotient, remainder);
        end
        run_op(-7, 3, "d_m7_3");
        run_op(100, -7, "d_100_m7");
        run_op(-128, -8, "d_m128_m8");
        run_op(-128, -1, "d_overflow");
        run_op(5, 0, "d_div0");
        run_op(-128, 1, "d_m128_1");
        run_op(127, -8, "d_127_m8");
    endtask

    task automatic test_back_to_back();
        // each new start is driven in the cycle done is high
        run_op(-50, 7, "b2b_0");
        run_op(9, 0, "b2b_1");
        run_op(-1, -1, "b2b_2");
        for (int i = 0; i < 6; i++)
            run_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)) - 8, "b2b_rand");
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int cyc;
        int extra;
        logic [EW-1:0] exp;
        exp_q.push_back(model(50, 5));
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dividend = 8'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        exp = exp_q.pop_front();
        total++;
        if (!done || {quotient, remainder, div_by_zero, overflow} !== exp) begin
            bad++;
            $display("FAIL busy_ignore result: done=%b q=%h r=%h, required done=1 q=%h r=%h",
                     done, quotient, remainder, exp[EW-1:VW+2], exp[VW+1:2]);
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL busy_ignore extra_done: got %0d extra done pulses, required 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dn++;
        end
        total++;
        if (dn !== 0) begin
            bad++;
            $display("FAIL reset_mid done: got %0d done pulses after abort, required 0", dn);
        end
    endtask

    task automatic test_recovery();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(9, 2, "recovery");
        @(negedge clk);
    endtask

    task automatic test_sweep();
        for (int a = -128; a <= 127; a++)
            for (int v = -8; v <= 7; v++)
                run_op(a, v, "sweep");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_recovery();
        test_sweep();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expected results left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
